// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - shared memory-request encodings and helpers
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_MEM_LEN_WIDTH  = 8;
    localparam int unsigned HPDCACHE_MEM_SIZE_WIDTH = 3;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_READ   = 2'b00,
        HPDCACHE_MEM_WRITE  = 2'b01,
        HPDCACHE_MEM_ATOMIC = 2'b10
    } hpdcache_mem_command_e;

    // log2 of the flit size in bytes, as carried in mem_req_size
    function automatic logic [HPDCACHE_MEM_SIZE_WIDTH-1:0] hpdcache_mem_size(input int unsigned bytes);
        logic [HPDCACHE_MEM_SIZE_WIDTH-1:0] s;
        s = '0;
        for (int unsigned b = bytes; b > 1; b = b >> 1) begin
            s = s + 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/hpdcache_mux.sv
// rtl/hpdcache_mux.sv - binary-select multiplexer over a flattened input vector
module hpdcache_mux #(
    parameter int unsigned NINPUT     = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = (NINPUT > 1) ? $clog2(NINPUT) : 1
) (
    input  logic [NINPUT*DATA_WIDTH-1:0] data_i,
    input  logic [SEL_WIDTH-1:0]         sel_i,
    output logic [DATA_WIDTH-1:0]        data_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < NINPUT; i++) begin
            if (sel_i == SEL_WIDTH'(i)) begin
                data_o = data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/hpdcache_mem_req_write_serializer.sv
// rtl/hpdcache_mem_req_write_serializer.sv - splits one cache-line write into a header plus data flits
module hpdcache_mem_req_write_serializer
    import hpdcache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH     = 512,
    parameter int unsigned MEM_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH     = 49,
    parameter int unsigned ID_WIDTH       = 4,
    localparam int unsigned NBEATS        = LINE_WIDTH / MEM_DATA_WIDTH,
    localparam int unsigned BEAT_WIDTH    = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int unsigned HDR_WIDTH     = ADDR_WIDTH + HPDCACHE_MEM_LEN_WIDTH + HPDCACHE_MEM_SIZE_WIDTH
                                            + ID_WIDTH + $bits(hpdcache_mem_command_e),
    localparam int unsigned FLIT_WIDTH    = MEM_DATA_WIDTH + MEM_DATA_WIDTH/8 + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      line_wr_valid_i,
    output logic                      line_wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]     line_wr_addr_i,
    input  logic [ID_WIDTH-1:0]       line_wr_id_i,
    input  logic [LINE_WIDTH-1:0]     line_wr_data_i,
    input  logic [LINE_WIDTH/8-1:0]   line_wr_be_i,
    input  logic                      mem_req_write_ready_i,
    output logic                      mem_req_write_valid_o,
    output logic [HDR_WIDTH-1:0]      mem_req_write_o,
    input  logic                      mem_req_write_data_ready_i,
    output logic                      mem_req_write_data_valid_o,
    output logic [FLIT_WIDTH-1:0]     mem_req_write_data_o,
    output logic                      busy_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]              mem_req_addr;
        logic [HPDCACHE_MEM_LEN_WIDTH-1:0]  mem_req_len;
        logic [HPDCACHE_MEM_SIZE_WIDTH-1:0] mem_req_size;
        logic [ID_WIDTH-1:0]                mem_req_id;
        hpdcache_mem_command_e              mem_req_command;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0]   mem_req_w_data;
        logic [MEM_DATA_WIDTH/8-1:0] mem_req_w_be;
        logic                        mem_req_w_last;
    } hpdcache_mem_req_w_t;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_WIDTH/8 - 1);

    state_e                    state_q, state_d;
    logic                      hdr_pend_q, hdr_pend_d;
    logic                      data_done_q, data_done_d;
    logic [BEAT_WIDTH-1:0]     beat_q, beat_d;
    logic                      capture;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic [LINE_WIDTH-1:0]     data_q;
    logic [LINE_WIDTH/8-1:0]   be_q;
    logic                      hdr_hs, data_hs, last_beat;
    logic [MEM_DATA_WIDTH-1:0]   beat_data;
    logic [MEM_DATA_WIDTH/8-1:0] beat_be;
    hpdcache_mem_req_t         hdr;
    hpdcache_mem_req_w_t       flit;

    // data_done_q stands in for beat == NBEATS, which the counter cannot hold
    assign last_beat                  = (beat_q == BEAT_WIDTH'(NBEATS - 1));
    assign mem_req_write_valid_o      = (state_q == ST_BUSY) && hdr_pend_q;
    assign mem_req_write_data_valid_o = (state_q == ST_BUSY) && !data_done_q;
    assign hdr_hs                     = mem_req_write_valid_o && mem_req_write_ready_i;
    assign data_hs                    = mem_req_write_data_valid_o && mem_req_write_data_ready_i;
    assign line_wr_ready_o            = (state_q == ST_IDLE);
    assign busy_o                     = (state_q == ST_BUSY);

    always_comb begin
        state_d     = state_q;
        hdr_pend_d  = hdr_pend_q;
        data_done_d = data_done_q;
        beat_d      = beat_q;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (line_wr_valid_i) begin
                    capture     = 1'b1;
                    hdr_pend_d  = 1'b1;
                    data_done_d = 1'b0;
                    beat_d      = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (hdr_hs) begin
                    hdr_pend_d = 1'b0;
                end
                if (data_hs) begin
                    if (last_beat) begin
                        data_done_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                    end
                end
                if (!hdr_pend_d && data_done_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            hdr_pend_q  <= 1'b0;
            data_done_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_pend_q  <= hdr_pend_d;
            data_done_q <= data_done_d;
            beat_q      <= beat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            addr_q <= line_wr_addr_i;
            id_q   <= line_wr_id_i;
            data_q <= line_wr_data_i;
            be_q   <= line_wr_be_i;
        end
    end

    hpdcache_mux #(.NINPUT(NBEATS), .DATA_WIDTH(MEM_DATA_WIDTH), .SEL_WIDTH(BEAT_WIDTH)) data_mux_i (
        .data_i (data_q),
        .sel_i  (beat_q),
        .data_o (beat_data)
    );

    hpdcache_mux #(.NINPUT(NBEATS), .DATA_WIDTH(MEM_DATA_WIDTH/8), .SEL_WIDTH(BEAT_WIDTH)) be_mux_i (
        .data_i (be_q),
        .sel_i  (beat_q),
        .data_o (beat_be)
    );

    always_comb begin
        hdr.mem_req_addr    = addr_q & ~OFFSET_MASK;
        hdr.mem_req_len     = HPDCACHE_MEM_LEN_WIDTH'(NBEATS - 1);
        hdr.mem_req_size    = hpdcache_mem_size(MEM_DATA_WIDTH / 8);
        hdr.mem_req_id      = id_q;
        hdr.mem_req_command = HPDCACHE_MEM_WRITE;
        flit.mem_req_w_data = beat_data;
        flit.mem_req_w_be   = beat_be;
        flit.mem_req_w_last = last_beat;
    end

    assign mem_req_write_o      = hdr;
    assign mem_req_write_data_o = flit;

    a_line_multiple : assert property (@(posedge clk_i) (LINE_WIDTH % MEM_DATA_WIDTH) == 0);

    a_hdr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_write_valid_o && !mem_req_write_ready_i)
        |=> (mem_req_write_valid_o && $stable(mem_req_write_o)));

    a_flit_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_write_data_valid_o && !mem_req_write_data_ready_i)
        |=> (mem_req_write_data_valid_o && $stable(mem_req_write_data_o)));

    a_no_accept_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(busy_o && line_wr_valid_i && line_wr_ready_o));

endmodule
